uart_multibyte_transmitter: RTL
===============================

Name: uart_multibyte_transmitter

Overview:
- Transmit-side counterpart of uart_multibyte_receiver. Accepts one message of 2^MSG_LOG_WIDTH bytes over a valid/ready handshake and serialises it on a single UART line as 8N1 frames.
- Used to return data (framebuffer readback, status words) from the FPGA to the host over RsTx.
- Byte order and bit timing are the exact inverse of the receiver, so that tx looped to rx reproduces the message.

Parameters:
- CLK_CYCLES, 33, clock cycles per UART bit period; legal range >= 2.
- MSG_LOG_WIDTH, 2, log2 of bytes per message; message width W = 8*2^MSG_LOG_WIDTH bits.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data  input  W  message to send; sampled only on the accept edge.
- valid  input  1  data is valid; a transfer occurs on a rising edge where valid && ready.
- ready  output  1  high only in IDLE; block can accept a message.
- uart_tx  output  1  serial line, registered, idles high.
- busy  output  1  equals !ready; for LEDs/status.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; uart_tx=1; ready=1; busy=0; all counters 0; shift register 0. Outputs take reset values without waiting for a clock edge.
- States:
  - IDLE -> START on valid && ready.
  - START -> DATA after CLK_CYCLES cycles.
  - DATA -> STOP after 8 bit periods.
  - STOP -> START if more bytes remain, else IDLE.
- Accept edge: latch data into an internal W-bit register. Later changes on data are ignored. uart_tx is driven 0 (start bit) from this same edge.
- Byte order: most-significant byte first (data[W-1:W-8] first, data[7:0] last), matching how the receiver shifts bytes in.
- Bit order within a byte: LSB first.
- Frame: 1 start bit (0), 8 data bits, 1 stop bit (1). Each bit is held exactly CLK_CYCLES clocks.
- Bit-period counter counts 0..CLK_CYCLES-1 and wraps. Bit index counts 0..7. Byte index counts 0..2^MSG_LOG_WIDTH-1. No counter may overflow or wrap at any other point.
- Between bytes of one message there is no gap: the stop bit is followed directly by the next start bit.
- Message length: 10*CLK_CYCLES*2^MSG_LOG_WIDTH clocks from the accept edge to the end of the last stop bit.
  - ready rises on the edge that ends the last stop bit.
  - The earliest next accept is one edge later, so back-to-back messages have exactly one extra idle-high clock between them.
- valid asserted while ready=0: ignored, no queuing. The upstream must hold valid until it sees ready.
- valid dropping mid-message: no effect; the message completes.
- Reset mid-message: the line returns high immediately, the message is discarded, and the block is in IDLE with ready=1 once reset_n is released.
- uart_tx comes directly from a flop; there is no combinational path from any input to uart_tx.

Test Plan:
- CLK_CYCLES=4, MSG_LOG_WIDTH=2, one-cycle valid with data=0xDEADBEEF ->
  - ready low for 160 cycles.
  - Line carries bytes DE, AD, BE, EF in that order.
  - First byte bits after the start bit: 0,1,1,1,1,0,1,1; each level held 4 clocks.
  - ready is high again at cycle 160.
- Loopback: tx -> uart_multibyte_receiver (same parameters), 100 random 32-bit messages -> receiver outputs the identical word for each, in order, with no errors.
- Back-to-back: valid held high with data=0x00000000 then 0xFFFFFFFF -> two messages with exactly 4+1 high clocks between the last data bit of message 1 and the start bit of message 2.
- Busy-ignore: second valid pulse with data=0x12345678 at cycle 50 of a message -> ignored; only the first message is sent; the line stays idle afterwards.
- Reset mid-byte: reset_n pulsed low at cycle 37 -> uart_tx=1 and ready=1 asynchronously. A new message of 0xA5A5A5A5 accepted after release is sent correctly.
- Edge parameters: CLK_CYCLES=2, MSG_LOG_WIDTH=0, data=0x80 -> 20-cycle frame: start bit, then 0,0,0,0,0,0,0,1, then stop bit; ready returns at cycle 20.

Source files
------------

// File: rtl/uart_multibyte_transmitter.sv
// Serialises one 2^MSG_LOG_WIDTH-byte message as back-to-back 8N1 frames,
// most-significant byte first, LSB first within each byte.
module uart_multibyte_transmitter #(
  parameter int CLK_CYCLES    = 33,
  parameter int MSG_LOG_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [8*(2**MSG_LOG_WIDTH)-1:0]     data,
  input  logic                                valid,
  output logic                                ready,
  output logic                                uart_tx,
  output logic                                busy
);

  localparam int NBYTES = 2**MSG_LOG_WIDTH;
  localparam int W      = 8*NBYTES;
  localparam int CW     = (CLK_CYCLES > 1) ? $clog2(CLK_CYCLES) : 1;
  localparam int BW     = (MSG_LOG_WIDTH > 0) ? MSG_LOG_WIDTH : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [W-1:0]    shreg_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [BW-1:0]   byte_q;
  logic            tx_q;
  logic            ready_q;

  logic [7:0]      cur_byte;
  logic            cnt_wrap;
  logic            last_byte;

  // The byte on the wire is always the top byte; it is shifted out after each stop bit.
  assign cur_byte  = shreg_q[W-1 -: 8];
  assign cnt_wrap  = (cnt_q == CW'(CLK_CYCLES-1));
  assign last_byte = (byte_q == BW'(NBYTES-1));

  assign ready   = ready_q;
  assign busy    = ~ready_q;
  assign uart_tx = tx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      if (state_q != IDLE) begin
        cnt_q <= cnt_wrap ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (valid) begin
            shreg_q <= data;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_wrap) begin
            tx_q    <= cur_byte[0];
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (cnt_wrap) begin
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              bit_q   <= '0;
              state_q <= STOP;
            end else begin
              tx_q  <= cur_byte[bit_q + 3'd1];
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (cnt_wrap) begin
            if (last_byte) begin
              byte_q  <= '0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              byte_q  <= byte_q + 1'b1;
              shreg_q <= shreg_q << 8;
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
